// File: rtl/latch_bank_wr_arbiter_if.sv
// Bus between the two write masters, the arbiter and the latch bank.
// Optional clear request is present only when LBA_CLEAR_EN is defined.
interface latch_bank_wr_arbiter_if #(
  parameter int S = 2,
  parameter int W = 8
);
  logic             req0;
  logic [S-1:0]     addr0;
  logic [W-1:0]     data0;
  logic             gnt0;
  logic             req1;
  logic [S-1:0]     addr1;
  logic [W-1:0]     data1;
  logic             gnt1;
  logic [W-1:0]     bank_data;
  logic [2**S-1:0]  bank_en;
  logic             busy;
`ifdef LBA_CLEAR_EN
  logic             clr;

  modport master (
    output req0, addr0, data0, req1, addr1, data1, clr,
    input  gnt0, gnt1, bank_data, bank_en, busy
  );

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1, clr,
    output gnt0, gnt1, bank_data, bank_en, busy
  );
`else
  modport master (
    output req0, addr0, data0, req1, addr1, data1,
    input  gnt0, gnt1, bank_data, bank_en, busy
  );

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1,
    output gnt0, gnt1, bank_data, bank_en, busy
  );
`endif
endinterface

// File: rtl/latch_bank_wr_arbiter.sv
// Write sequencer and round-robin arbiter for a bank of 2**S D-latches.
// Each write runs SETUP (data driven), PULSE (one enable high), HOLD
// (data still stable) so the latch never sees data move under its enable.
// Optional feature macro: LBA_CLEAR_EN adds a clear-all operation.
module latch_bank_wr_arbiter #(
  parameter int S = 2,
  parameter int W = 8
) (
  input logic                    clk,
  input logic                    reset,
  latch_bank_wr_arbiter_if.slave bus
);

  localparam int N = 2**S;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t         state, state_next;
  logic           rr_last, rr_last_next;
  logic [S-1:0]   cap_addr;
  logic           cap_clear;
  logic           clr_req;
  logic           win_valid;
  logic           win_sel;
  logic           start_clear;

  logic           gnt0_q, gnt1_q, busy_q;
  logic [W-1:0]   bank_data_q;
  logic [N-1:0]   bank_en_q;
  logic           gnt0_d, gnt1_d, busy_d;
  logic [W-1:0]   bank_data_d;
  logic [N-1:0]   bank_en_d;

`ifdef LBA_CLEAR_EN
  assign clr_req = bus.clr;
`else
  assign clr_req = 1'b0;
`endif

  // State, arbitration memory, captured write and registered outputs.
  // NOTE: the captured address/flag are reset too, so nothing in the block
  // ever powers up as X and an aborted write leaves a known state behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      cap_addr    <= '0;
      cap_clear   <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      busy_q      <= 1'b0;
      bank_data_q <= '0;
      bank_en_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state       <= state_next;
      rr_last     <= rr_last_next;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      busy_q      <= busy_d;
      bank_data_q <= bank_data_d;
      bank_en_q   <= bank_en_d;
      if (start_clear) begin
        cap_clear <= 1'b1;
      end else if (win_valid) begin
        cap_clear <= 1'b0;
        cap_addr  <= win_sel ? bus.addr1 : bus.addr0;
      end
    end
  end

  // Next state and arbitration; requests are only looked at in IDLE/HOLD.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise the
    // paths that do not assign it would infer a latch.
    state_next   = state;
    rr_last_next = rr_last;
    win_valid    = 1'b0;
    win_sel      = 1'b0;
    start_clear  = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (clr_req) begin
          start_clear = 1'b1;
          state_next  = SETUP;
        end else if (bus.req0 || bus.req1) begin
          win_valid  = 1'b1;
          state_next = SETUP;
          if (bus.req0 && bus.req1) begin
            win_sel      = ~rr_last;
            rr_last_next = ~rr_last;
          end else begin
            win_sel = bus.req1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SETUP:   state_next = PULSE;
      PULSE:   state_next = HOLD;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition.
  always_comb begin
    gnt0_d      = win_valid && !win_sel;
    gnt1_d      = win_valid && win_sel;
    busy_d      = (state_next != IDLE);
    bank_data_d = bank_data_q;
    bank_en_d   = '0;
    if (start_clear) begin
      bank_data_d = '0;
    end else if (win_valid) begin
      bank_data_d = win_sel ? bus.data1 : bus.data0;
    end
    if (state == SETUP) begin
      if (cap_clear) begin
        bank_en_d = '1;
      end else begin
        bank_en_d[cap_addr] = 1'b1;
      end
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.busy      = busy_q;
  assign bus.bank_data = bank_data_q;
  assign bus.bank_en   = bank_en_q;

endmodule
